// File: rtl/fmdll_div_gen_pkg.sv
// Shared state encoding, minimum ratio and ratio clamp for the FMDLL divider/strobe generator.
// DIVM_STRETCH_EN selects the two-cycle div_m strobe, which needs a minimum ratio of 3.
package fmdll_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      RECFG = 2'd2
   } fmdll_state_e;

`ifdef DIVM_STRETCH_EN
   localparam int unsigned MIN_RATIO = 3;
`else
   localparam int unsigned MIN_RATIO = 2;
`endif

   // Ratios below MIN_RATIO would make back-to-back strobes overlap or vanish.
   function automatic logic [31:0] clamp_ratio(input logic [31:0] r);
      return (r < MIN_RATIO) ? MIN_RATIO : r;
   endfunction

endpackage

// File: rtl/fmdll_div_gen_if.sv
// Control/status bundle between the hold-control requester and the divider generator.
// Every status signal is driven straight from a register inside the generator.
interface fmdll_div_gen_if #(
   parameter int N_W = 6
);
   logic           en;
   logic           cfg_req;
   logic [N_W-1:0] cfg_ratio;
   logic           cfg_m;
   logic           cfg_ack;
   logic           clk2;
   logic           clk4;
   logic           div_m;
   logic           m;
   logic           frame_busy;

   modport master (
      output en, cfg_req, cfg_ratio, cfg_m,
      input  cfg_ack, clk2, clk4, div_m, m, frame_busy
   );

   modport slave (
      input  en, cfg_req, cfg_ratio, cfg_m,
      output cfg_ack, clk2, clk4, div_m, m, frame_busy
   );
endinterface

// File: rtl/fmdll_div_gen_phase_cnt.sv
// Modulo-N frame counter with frame-aligned f/2 and f/4 phases; phases update with the count.
// No backpressure: run_i gates counting, realign_i forces the frame-start state.
module fmdll_phase_cnt #(
   parameter int N_W = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           run_i,
   input  logic           realign_i,
   input  logic [N_W-1:0] ratio_i,
   output logic           clk2_o,
   output logic           clk4_o,
   output logic           wrap_o
);

   localparam logic [N_W-1:0] ONE = N_W'(1);

   logic [N_W-1:0] cnt_q, cnt_d;
   logic           clk2_q, clk2_d;
   logic           clk4_q, clk4_d;

   assign wrap_o = run_i && (cnt_q == (ratio_i - ONE));

   // A wrap returns both phases to 0 so each frame starts at phase 0.
   always_comb begin
      cnt_d  = cnt_q;
      clk2_d = clk2_q;
      clk4_d = clk4_q;
      if (realign_i || wrap_o) begin
         cnt_d  = '0;
         clk2_d = 1'b0;
         clk4_d = 1'b0;
      end else if (run_i) begin
         cnt_d  = cnt_q + ONE;
         clk2_d = ~clk2_q;
         clk4_d = clk4_q ^ clk2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         clk2_q <= 1'b0;
         clk4_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         clk2_q <= clk2_d;
         clk4_q <= clk4_d;
      end
   end

   assign clk2_o = clk2_q;
   assign clk4_o = clk4_q;

endmodule

// File: rtl/fmdll_div_gen.sv
// FMDLL phase/strobe generator: IDLE/RUN/RECFG FSM, req/ack reconfiguration at frame wrap; all outputs 1-cycle registered.
// cfg_req is held by the requester until cfg_ack; DIVM_STRETCH_EN stretches div_m to two cycles.
module fmdll_div_gen
   import fmdll_pkg::*;
#(
   parameter int   N_W   = 6,
   parameter int   N_DEF = 8,
   parameter logic M_DEF = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   fmdll_div_gen_if.slave  bus_if
);

   localparam logic [1:0]     ST_IDLE   = IDLE;
   localparam logic [1:0]     ST_RUN    = RUN;
   localparam logic [1:0]     ST_RECFG  = RECFG;
   localparam logic [N_W-1:0] RATIO_RST = N_W'(clamp_ratio(32'(N_DEF)));

   logic [1:0]     state_q, state_d;
   logic [N_W-1:0] ratio_q, ratio_d;
   logic           m_q, m_d;
   logic           ack_q, ack_d;
   logic           busy_q, busy_d;
   logic           div_m_q, div_m_d;
   logic           wrap;
   logic           clk2, clk4;

   fmdll_phase_cnt #(
      .N_W (N_W)
   ) u_phase_cnt (
      .clk       (clk),
      .rst       (rst),
      .run_i     (state_q == ST_RUN),
      .realign_i (state_q != ST_RUN),
      .ratio_i   (ratio_q),
      .clk2_o    (clk2),
      .clk4_o    (clk4),
      .wrap_o    (wrap)
   );

   // cfg_req is only looked at in IDLE or on the last cycle of a frame.
   always_comb begin
      state_d = state_q;
      ratio_d = ratio_q;
      m_d     = m_q;
      case (state_q)
         ST_IDLE: begin
            if (bus_if.cfg_req) begin
               state_d = ST_RECFG;
            end else if (bus_if.en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (wrap) begin
               if (bus_if.cfg_req) begin
                  state_d = ST_RECFG;
               end else if (!bus_if.en) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RECFG: begin
            ratio_d = N_W'(clamp_ratio(32'(bus_if.cfg_ratio)));
            m_d     = bus_if.cfg_m;
            state_d = bus_if.en ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ack_d  = (state_d == ST_RECFG);
   assign busy_d = (state_d == ST_RUN);

`ifdef DIVM_STRETCH_EN
   logic wrap_dly_q;

   // The second strobe cycle follows the wrap whatever state comes next.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_dly_q <= 1'b0;
      end else begin
         wrap_dly_q <= wrap;
      end
   end

   assign div_m_d = wrap | wrap_dly_q;
`else
   assign div_m_d = wrap;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ratio_q <= RATIO_RST;
         m_q     <= M_DEF;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         div_m_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ratio_q <= ratio_d;
         m_q     <= m_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         div_m_q <= div_m_d;
      end
   end

   assign bus_if.cfg_ack    = ack_q;
   assign bus_if.clk2       = clk2;
   assign bus_if.clk4       = clk4;
   assign bus_if.div_m      = div_m_q;
   assign bus_if.m          = m_q;
   assign bus_if.frame_busy = busy_q;

endmodule

// File: tb/tb_fmdll_div_gen.sv
// Directed + randomized bench for fmdll_div_gen against a frame-position reference model.
// Outputs are sampled on the falling edge; inputs change only on the falling edge.
module tb_fmdll_div_gen;

   localparam int   N_W   = 6;
   localparam int   N_DEF = 8;
   localparam logic M_DEF = 1'b0;
`ifdef DIVM_STRETCH_EN
   localparam int   MINR    = 3;
   localparam int   PULSE_W = 2;
`else
   localparam int   MINR    = 2;
   localparam int   PULSE_W = 1;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_RECFG = 2;

   logic clk;
   logic rst;

   fmdll_div_gen_if #(.N_W(N_W)) bus_if ();

   fmdll_div_gen #(
      .N_W   (N_W),
      .N_DEF (N_DEF),
      .M_DEF (M_DEF)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: mode, position within the frame, active ratio and mode bit.
   int   st, pos, ratio;
   logic mm, last_prev;
   logic exp_ack, exp_clk2, exp_clk4, exp_div, exp_m, exp_busy;

   function automatic int clampr(input int r);
      return (r < MINR) ? MINR : r;
   endfunction

   function automatic void model_reset();
      st = M_IDLE; pos = 0; ratio = clampr(N_DEF); mm = M_DEF; last_prev = 1'b0;
      exp_ack = 1'b0; exp_clk2 = 1'b0; exp_clk4 = 1'b0;
      exp_div = 1'b0; exp_m = M_DEF; exp_busy = 1'b0;
   endfunction

   function automatic void model_advance();
      logic last;
      if (rst) begin
         model_reset();
         return;
      end
      last = (st == M_RUN) && (pos == ratio - 1);
`ifdef DIVM_STRETCH_EN
      exp_div = last || last_prev;
`else
      exp_div = last;
`endif
      last_prev = last;
      if (st == M_IDLE) begin
         if (bus_if.cfg_req) st = M_RECFG;
         else if (bus_if.en) begin st = M_RUN; pos = 0; end
      end else if (st == M_RUN) begin
         if (last) begin
            pos = 0;
            if (bus_if.cfg_req) st = M_RECFG;
            else if (!bus_if.en) st = M_IDLE;
         end else begin
            pos = pos + 1;
         end
      end else begin
         ratio = clampr(int'(bus_if.cfg_ratio));
         mm    = bus_if.cfg_m;
         pos   = 0;
         st    = bus_if.en ? M_RUN : M_IDLE;
      end
      // Phases are a pure function of where we are inside the frame.
      exp_clk2 = (st == M_RUN) && (pos % 2 == 1);
      exp_clk4 = (st == M_RUN) && ((pos / 2) % 2 == 1);
      exp_ack  = (st == M_RECFG);
      exp_busy = (st == M_RUN);
      exp_m    = mm;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_all();
      chk("cfg_ack", bus_if.cfg_ack, exp_ack);
      chk("clk2", bus_if.clk2, exp_clk2);
      chk("clk4", bus_if.clk4, exp_clk4);
      chk("div_m", bus_if.div_m, exp_div);
      chk("m", bus_if.m, exp_m);
      chk("frame_busy", bus_if.frame_busy, exp_busy);
   endtask

   task automatic step();
      @(posedge clk);
      model_advance();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_cfg(input int r, input logic mv);
      bit got;
      got = 1'b0;
      bus_if.cfg_ratio = N_W'(r);
      bus_if.cfg_m     = mv;
      bus_if.cfg_req   = 1'b1;
      for (int i = 0; i < 100 && !got; i++) begin
         step();
         got = exp_ack;
      end
      chk("cfg_ack_seen", bus_if.cfg_ack, 1'b1);
      bus_if.cfg_req = 1'b0;
   endtask

   task automatic run_until_pos(input int p);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         step();
         got = (st == M_RUN) && (pos == p);
      end
      chk("reach_frame_pos", got, 1'b1);
   endtask

   // Rising-edge spacing and high width of div_m, measured on the DUT.
   task automatic measure(output int period, output int width);
      logic prev;
      bit   found, in_p;
      period = -1; width = -1; found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         prev = bus_if.div_m;
         step();
         found = !prev && bus_if.div_m;
      end
      if (found) begin
         width = 1; in_p = 1'b1; found = 1'b0;
         for (int i = 1; i < 100 && !found; i++) begin
            prev = bus_if.div_m;
            step();
            if (in_p && bus_if.div_m) width++;
            else in_p = 1'b0;
            if (!prev && bus_if.div_m) begin
               period = i;
               found  = 1'b1;
            end
         end
      end
   endtask

   initial begin
      int per, wid;
      bit req_on;
      rst = 1'b1;
      bus_if.en = 1'b0; bus_if.cfg_req = 1'b0; bus_if.cfg_ratio = '0; bus_if.cfg_m = 1'b0;
      model_reset();
      step();
      step();
      rst = 1'b0;
      chk("rst_clk2", bus_if.clk2, 1'b0);
      chk("rst_clk4", bus_if.clk4, 1'b0);
      chk("rst_div_m", bus_if.div_m, 1'b0);
      chk("rst_cfg_ack", bus_if.cfg_ack, 1'b0);
      chk("rst_busy", bus_if.frame_busy, 1'b0);
      chk("rst_m", bus_if.m, M_DEF);
      step();

      // Default ratio after reset.
      bus_if.en = 1'b1;
      repeat (20) step();
      measure(per, wid);
      chk_int("period_ndef", per, clampr(N_DEF));
      chk_int("width_ndef", wid, PULSE_W);

      // Mid-frame request: ratio 5, m=1.
      run_until_pos(3);
      do_cfg(5, 1'b1);
      repeat (12) step();
      measure(per, wid);
      chk_int("period_r5", per, 5);

      // Clamp of ratios 0 and 1.
      do_cfg(0, 1'b0);
      repeat (4) step();
      measure(per, wid);
      chk_int("period_r0", per, MINR);
      do_cfg(1, 1'b1);
      repeat (4) step();
      measure(per, wid);
      chk_int("period_r1", per, MINR);

      // Ratio 6 with a reconfiguration boundary to exercise the strobe across RECFG.
      do_cfg(6, 1'b0);
      measure(per, wid);
      chk_int("period_r6", per, 6);
      chk_int("width_r6", wid, PULSE_W);
      do_cfg(6, 1'b1);
      repeat (8) step();

      // en dropped at cnt=2: the frame completes, then IDLE.
      do_cfg(8, 1'b0);
      run_until_pos(2);
      bus_if.en = 1'b0;
      repeat (12) step();
      chk("idle_busy", bus_if.frame_busy, 1'b0);
      chk("idle_clk2", bus_if.clk2, 1'b0);

      // Request from IDLE together with enable goes through RECFG first.
      bus_if.en = 1'b1;
      do_cfg(4, 1'b1);
      repeat (10) step();

      // Request and enable fall at the same wrap: RECFG, then IDLE.
      run_until_pos(1);
      bus_if.en = 1'b0;
      do_cfg(7, 1'b0);
      repeat (6) step();
      chk("recfg_then_idle", bus_if.frame_busy, 1'b0);
      bus_if.en = 1'b1;
      do_cfg(8, 1'b1);

      // Asynchronous reset mid-frame with a pending request.
      run_until_pos(4);
      bus_if.cfg_req = 1'b1;
      bus_if.cfg_ratio = N_W'(3);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      bus_if.cfg_req = 1'b0;
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      measure(per, wid);
      chk_int("period_after_rst", per, clampr(N_DEF));

      // Randomized traffic with a well-behaved requester.
      req_on = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (!req_on && $urandom_range(0, 15) == 0) begin
            bus_if.cfg_ratio = N_W'($urandom_range(0, 20));
            bus_if.cfg_m     = 1'($urandom_range(0, 1));
            bus_if.cfg_req   = 1'b1;
            req_on = 1'b1;
         end
         if ($urandom_range(0, 24) == 0) bus_if.en = ~bus_if.en;
         step();
         if (req_on && exp_ack) begin
            bus_if.cfg_req = 1'b0;
            req_on = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
